// File: rtl/hah_audio_pkg.sv
// Shared audio types: I2S receiver FSM states and stereo channel indices.
package hah_audio_pkg;

   typedef enum logic [1:0] {
      RX_SYNC,
      RX_LEFT,
      RX_RIGHT
   } i2s_rx_state_t;

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

endpackage

// File: rtl/audio_pin_sync.sv
// Multi-stage pin synchroniser with a one-cycle 0->1 edge pulse.
module audio_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic q,
   output logic rise
);

   logic [STAGES-1:0] sr;
   logic              prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr   <= '0;
         prev <= 1'b0;
      end else begin
         sr   <= {sr[STAGES-2:0], din};
         prev <= sr[STAGES-1];
      end
   end

   assign q    = sr[STAGES-1];
   assign rise = sr[STAGES-1] & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S slave receiver producing stereo frames with a one-cycle strobe.
// Define I2S_RX_FRAME_CHECK_EN to add the sticky frame_err slot-length check.
module i2s_rx
   import hah_audio_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int SLOT_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i2s_bclk,
   input  logic                   i2s_lrclk,
   input  logic                   i2s_sdata,
   output logic [1:0][DATA_W-1:0] audio_out,
   output logic                   sample_en
`ifdef I2S_RX_FRAME_CHECK_EN
   ,
   output logic                   frame_err
`endif
);

   localparam int CW = $clog2(SLOT_W + 1);
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic bclk_lvl_unused, lr_edge_unused, sd_edge_unused;
   logic bclk_ev, lr_s, sd_s;

   audio_pin_sync #(.STAGES(SYNC_STAGES)) u_bclk (
      .clk(clk), .reset(reset), .din(i2s_bclk),
      .q(bclk_lvl_unused), .rise(bclk_ev)
   );

   audio_pin_sync #(.STAGES(SYNC_STAGES)) u_lrclk (
      .clk(clk), .reset(reset), .din(i2s_lrclk),
      .q(lr_s), .rise(lr_edge_unused)
   );

   audio_pin_sync #(.STAGES(SYNC_STAGES)) u_sdata (
      .clk(clk), .reset(reset), .din(i2s_sdata),
      .q(sd_s), .rise(sd_edge_unused)
   );

   i2s_rx_state_t     state, state_nxt;
   logic              lr_prev;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg, word, left_reg;
   logic [IW-1:0]     idx;
   logic              bound, in_data, latch_l, deliver;

   always_comb begin
      bound     = bclk_ev && (lr_s != lr_prev);
      in_data   = bit_cnt < CW'(DATA_W);
      idx       = IW'(DATA_W - 1) - bit_cnt[IW-1:0];
      word      = shreg;
      state_nxt = state;
      latch_l   = 1'b0;
      deliver   = 1'b0;
      if (in_data)
         word[idx] = sd_s;
      // The boundary bit is the old slot's LSB, so it is already in word.
      if (bound) begin
         unique case (state)
            RX_SYNC: begin
               if (!lr_s)
                  state_nxt = RX_LEFT;
            end
            RX_LEFT: begin
               if (lr_s) begin
                  latch_l   = 1'b1;
                  state_nxt = RX_RIGHT;
               end
            end
            RX_RIGHT: begin
               if (!lr_s) begin
                  deliver   = 1'b1;
                  state_nxt = RX_LEFT;
               end
            end
            default: state_nxt = RX_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= RX_SYNC;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lr_prev   <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         left_reg  <= '0;
         audio_out <= '0;
         sample_en <= 1'b0;
      end else begin
         sample_en <= deliver;
         if (bclk_ev) begin
            lr_prev <= lr_s;
            if (bound) begin
               bit_cnt <= '0;
               shreg   <= '0;
            end else begin
               shreg <= word;
               if (bit_cnt < CW'(SLOT_W))
                  bit_cnt <= bit_cnt + CW'(1);
            end
         end
         if (latch_l)
            left_reg <= word;
         if (deliver) begin
            audio_out[CH_L] <= left_reg;
            audio_out[CH_R] <= word;
         end
      end
   end

`ifdef I2S_RX_FRAME_CHECK_EN
   logic [CW:0] slot_cnt;

   assign slot_cnt = {1'b0, bit_cnt} + (CW + 1)'(1);

   always_ff @(posedge clk) begin
      if (reset)
         frame_err <= 1'b0;
      else if (bound && state != RX_SYNC &&
               slot_cnt != (CW + 1)'(SLOT_W))
         frame_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: BFM drives standard I2S, monitor checks frames.
module tb_i2s_rx;

   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bclk = 1'b0;
   logic lrclk = 1'b0;
   logic sdata = 1'b0;
   logic [1:0][DW-1:0] audio_out;
   logic sample_en;
`ifdef I2S_RX_FRAME_CHECK_EN
   logic frame_err;
`endif

   i2s_rx #(.DATA_W(16), .SLOT_W(32), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .reset(reset),
      .i2s_bclk(bclk),
      .i2s_lrclk(lrclk),
      .i2s_sdata(sdata),
      .audio_out(audio_out),
      .sample_en(sample_en)
`ifdef I2S_RX_FRAME_CHECK_EN
      ,
      .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total = 0;
   int strobes = 0;
   int pushes = 0;
   logic [31:0] exp_q[$];
   logic se_d = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      total++;
      if (act === expv)
         passed++;
      else
         $display("FAIL %s: got %h want %h", name, act, expv);
   endtask

   // 8 clk per BCLK; data and lrclk change with the falling edge
   task automatic send_bit(logic lr, logic d);
      lrclk = lr;
      sdata = d;
      #40;
      bclk = 1'b1;
      #40;
      bclk = 1'b0;
   endtask

   // last bit of a slot goes out with the next slot's lrclk
   task automatic send_slot(logic lr_this, logic lr_next,
                            logic [63:0] v, int n);
      for (int i = 0; i < n - 1; i++)
         send_bit(lr_this, v[63-i]);
      send_bit(lr_next, v[63-(n-1)]);
   endtask

   task automatic frame(logic [63:0] lv, int nl, logic [63:0] rv, int nr,
                        logic [31:0] expv, bit push);
      if (push) begin
         exp_q.push_back(expv);
         pushes++;
      end
      send_slot(1'b0, 1'b1, lv, nl);
      send_slot(1'b1, 1'b0, rv, nr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_audio", audio_out, 0);
      check("rst_strobe", sample_en, 0);
`ifdef I2S_RX_FRAME_CHECK_EN
      check("rst_frame_err", frame_err, 0);
`endif
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sample_en) begin
         strobes++;
         check("strobe_width", se_d, 0);
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_strobe: got %h want none", audio_out);
         end else begin
            check("frame", audio_out, exp_q.pop_front());
         end
      end
      se_d = sample_en;
   end

   initial begin
      logic [15:0] l, r;
      int snap;

      do_reset();

      // leading 1->0 sync, then L=8001 R=7FFE
      send_slot(1'b1, 1'b0, 64'hF0F0_F0F0_0000_0000, 32);
      frame({16'h8001, 48'h0}, 32, {16'h7FFE, 48'h0}, 32,
            {16'h7FFE, 16'h8001}, 1);
      #200;
      check("first_frame_count", strobes, 1);

      for (int i = 0; i < 40; i++) begin
         l = 16'($urandom);
         r = 16'($urandom);
         frame({l, 48'h0}, 32, {r, 48'h0}, 32, {r, l}, 1);
      end
      #200;
`ifdef I2S_RX_FRAME_CHECK_EN
      check("err_clean_stream", frame_err, 0);
`endif

      // stream begins mid right slot
      do_reset();
      snap = strobes;
      send_slot(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 13);
      #200;
      check("no_early_strobe", strobes, snap);
      frame({16'h5A5A, 48'h0}, 32, {16'hC3C3, 48'h0}, 32,
            {16'hC3C3, 16'h5A5A}, 1);

      // 12-bit slots: missing LSBs read as zero
      frame({12'hABC, 52'h0}, 12, {12'h123, 52'h0}, 12,
            {16'h1230, 16'hABC0}, 1);
      #200;
`ifdef I2S_RX_FRAME_CHECK_EN
      check("err_short_slot", frame_err, 1);
`endif

      // 40-bit left slot: extra bits dropped
      do_reset();
      send_slot(1'b1, 1'b0, 64'h0, 32);
      frame({16'h1234, 24'hFF_FFFF, 24'h0}, 40, {16'hBEEF, 48'h0}, 32,
            {16'hBEEF, 16'h1234}, 1);
      #200;
`ifdef I2S_RX_FRAME_CHECK_EN
      check("err_long_slot", frame_err, 1);
`endif

      // reset in the middle of a left slot
      do_reset();
      send_slot(1'b1, 1'b0, 64'h0, 32);
      frame({16'hA5A5, 48'h0}, 32, {16'h0F0F, 48'h0}, 32,
            {16'h0F0F, 16'hA5A5}, 1);
      for (int i = 0; i < 10; i++)
         send_bit(1'b0, 1'b1);
      #200;
      check("pre_reset_out", audio_out, {16'h0F0F, 16'hA5A5});
      do_reset();
      snap = strobes;
      send_slot(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 22);
      send_slot(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32);
      #200;
      check("no_stale_strobe", strobes, snap);
      frame({16'h2222, 48'h0}, 32, {16'h1111, 48'h0}, 32,
            {16'h1111, 16'h2222}, 1);
      #200;

      check("queue_empty", exp_q.size(), 0);
      check("strobe_count", strobes, pushes);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
